// File: rtl/insa_buf_ctrl.sv
// INSA buffer table controller: entry allocation, round-robin ALU/LSU read arbitration,
// sequenced table clear and the sticky crash-enable flag.
module insa_buf_ctrl #(
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned IDX_W      = $clog2(NR_ENTRIES),
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_first_i,
    input  logic [DATA_W-1:0] wr_last_i,
    output logic [IDX_W-1:0]  wr_idx_o,

    input  logic              alu_req_i,
    input  logic [IDX_W-1:0]  alu_idx_i,
    output logic              alu_gnt_o,
    output logic              alu_rvalid_o,
    output logic [DATA_W-1:0] alu_first_o,
    output logic [DATA_W-1:0] alu_last_o,
    output logic              alu_hit_o,

    input  logic              lsu_req_i,
    input  logic [IDX_W-1:0]  lsu_idx_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_first_o,
    output logic [DATA_W-1:0] lsu_last_o,
    output logic              lsu_hit_o,

    input  logic              clear_i,
    output logic              busy_o,
    output logic              data_in_buffer_o,

    input  logic              en_crash_set_i,
    output logic              en_crash_o
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NR_ENTRIES - 1);
    localparam logic [IDX_W:0]   CountMax = (IDX_W + 1)'(NR_ENTRIES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [IDX_W-1:0]   head_q, head_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               rr_lsu_q, rr_lsu_d;
    logic               dib_q;
    logic               crash_q;

    logic [NR_ENTRIES-1:0] valid_q;
    logic [DATA_W-1:0]     first_q [NR_ENTRIES];
    logic [DATA_W-1:0]     last_q  [NR_ENTRIES];

    logic              alu_rvalid_q, lsu_rvalid_q;
    logic              alu_hit_q, lsu_hit_q;
    logic [DATA_W-1:0] alu_first_q, alu_last_q;
    logic [DATA_W-1:0] lsu_first_q, lsu_last_q;

    logic idle;
    logic wr_accept;

    assign idle      = (state_q == StIdle);
    assign wr_ready_o = idle && (count_q < CountMax);
    assign wr_accept = wr_valid_i && wr_ready_o;
    assign wr_idx_o  = head_q;

    // Round robin: on contention the port that did not win last time is served.
    assign alu_gnt_o = idle && alu_req_i && (!lsu_req_i || rr_lsu_q);
    assign lsu_gnt_o = idle && lsu_req_i && (!alu_req_i || !rr_lsu_q);

    always_comb begin
        rr_lsu_d = rr_lsu_q;
        if (alu_gnt_o) begin
            rr_lsu_d = 1'b0;
        end else if (lsu_gnt_o) begin
            rr_lsu_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        head_d  = head_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (wr_accept) begin
                    head_d  = head_q + IDX_W'(1);
                    count_d = count_q + (IDX_W + 1)'(1);
                end
                if (clear_i) begin
                    state_d = StClear;
                    sweep_d = '0;
                end
            end
            StClear: begin
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == LastIdx) begin
                    state_d = StIdle;
                    head_d  = '0;
                    count_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            sweep_q  <= '0;
            head_q   <= '0;
            count_q  <= '0;
            rr_lsu_q <= 1'b1;
            dib_q    <= 1'b0;
            crash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            head_q   <= head_d;
            count_q  <= count_d;
            rr_lsu_q <= rr_lsu_d;
            dib_q    <= (count_d != '0);
            if (en_crash_set_i) begin
                crash_q <= 1'b1;
            end
        end
    end

    // Allocation and the sweep never overlap: writes are only accepted in idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            if (wr_accept) begin
                valid_q[head_q] <= 1'b1;
            end
            if (state_q == StClear) begin
                valid_q[sweep_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            first_q[head_q] <= wr_first_i;
            last_q[head_q]  <= wr_last_i;
        end
    end

    // Read data is taken from the pre-edge table, so a same-cycle write is not visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_rvalid_q <= 1'b0;
            alu_hit_q    <= 1'b0;
            alu_first_q  <= '0;
            alu_last_q   <= '0;
            lsu_rvalid_q <= 1'b0;
            lsu_hit_q    <= 1'b0;
            lsu_first_q  <= '0;
            lsu_last_q   <= '0;
        end else begin
            alu_rvalid_q <= alu_gnt_o;
            lsu_rvalid_q <= lsu_gnt_o;
            if (alu_gnt_o) begin
                alu_hit_q   <= valid_q[alu_idx_i];
                alu_first_q <= first_q[alu_idx_i];
                alu_last_q  <= last_q[alu_idx_i];
            end
            if (lsu_gnt_o) begin
                lsu_hit_q   <= valid_q[lsu_idx_i];
                lsu_first_q <= first_q[lsu_idx_i];
                lsu_last_q  <= last_q[lsu_idx_i];
            end
        end
    end

    assign alu_rvalid_o     = alu_rvalid_q;
    assign alu_hit_o        = alu_hit_q;
    assign alu_first_o      = alu_first_q;
    assign alu_last_o       = alu_last_q;
    assign lsu_rvalid_o     = lsu_rvalid_q;
    assign lsu_hit_o        = lsu_hit_q;
    assign lsu_first_o      = lsu_first_q;
    assign lsu_last_o       = lsu_last_q;
    assign busy_o           = (state_q == StClear);
    assign data_in_buffer_o = dib_q;
    assign en_crash_o       = crash_q;

endmodule

// File: tb/tb_insa_buf_ctrl.sv
// Self-checking bench for insa_buf_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural table model.
module tb_insa_buf_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [DW-1:0] wr_first_i, wr_last_i;
    logic [IW-1:0] wr_idx_o;
    logic          alu_req_i, alu_gnt_o, alu_rvalid_o, alu_hit_o;
    logic [IW-1:0] alu_idx_i;
    logic [DW-1:0] alu_first_o, alu_last_o;
    logic          lsu_req_i, lsu_gnt_o, lsu_rvalid_o, lsu_hit_o;
    logic [IW-1:0] lsu_idx_i;
    logic [DW-1:0] lsu_first_o, lsu_last_o;
    logic          clear_i, busy_o, data_in_buffer_o;
    logic          en_crash_set_i, en_crash_o;

    int errors = 0;
    int checks = 0;

    insa_buf_ctrl #(.NR_ENTRIES(N), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_first_i(wr_first_i),
        .wr_last_i(wr_last_i), .wr_idx_o(wr_idx_o),
        .alu_req_i(alu_req_i), .alu_idx_i(alu_idx_i), .alu_gnt_o(alu_gnt_o),
        .alu_rvalid_o(alu_rvalid_o), .alu_first_o(alu_first_o), .alu_last_o(alu_last_o),
        .alu_hit_o(alu_hit_o),
        .lsu_req_i(lsu_req_i), .lsu_idx_i(lsu_idx_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_first_o(lsu_first_o), .lsu_last_o(lsu_last_o),
        .lsu_hit_o(lsu_hit_o),
        .clear_i(clear_i), .busy_o(busy_o), .data_in_buffer_o(data_in_buffer_o),
        .en_crash_set_i(en_crash_set_i), .en_crash_o(en_crash_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural model: a table of records, a free-slot pointer, an occupancy count and
    // a countdown for the clear (the table is wiped when the countdown expires).
    bit          m_valid [N];
    logic [DW-1:0] m_first [N];
    logic [DW-1:0] m_last  [N];
    int          m_head, m_count, m_clear_left;
    bit          m_rr_lsu, m_crash;

    bit          e_wr_ready, e_alu_gnt, e_lsu_gnt;
    int          e_wr_idx;
    bit          e_alu_rvalid, e_lsu_rvalid, e_alu_hit, e_lsu_hit, e_dib;
    logic [DW-1:0] e_alu_first, e_alu_last, e_lsu_first, e_lsu_last;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_head = 0; m_count = 0; m_clear_left = 0;
        m_rr_lsu = 1'b1; m_crash = 1'b0;
        e_alu_rvalid = 0; e_lsu_rvalid = 0; e_alu_hit = 0; e_lsu_hit = 0; e_dib = 0;
        e_alu_first = '0; e_alu_last = '0; e_lsu_first = '0; e_lsu_last = '0;
    endtask

    task automatic model_comb();
        bit free_run;
        free_run   = (m_clear_left == 0);
        e_wr_ready = free_run && (m_count < N);
        e_alu_gnt  = free_run && alu_req_i && (!lsu_req_i || m_rr_lsu);
        e_lsu_gnt  = free_run && lsu_req_i && (!alu_req_i || !m_rr_lsu);
        e_wr_idx   = m_head;
    endtask

    task automatic model_clock();
        e_alu_rvalid = e_alu_gnt;
        e_lsu_rvalid = e_lsu_gnt;
        if (e_alu_gnt) begin
            e_alu_hit = m_valid[alu_idx_i];
            e_alu_first = m_first[alu_idx_i];
            e_alu_last = m_last[alu_idx_i];
        end
        if (e_lsu_gnt) begin
            e_lsu_hit = m_valid[lsu_idx_i];
            e_lsu_first = m_first[lsu_idx_i];
            e_lsu_last = m_last[lsu_idx_i];
        end
        if (e_alu_gnt) m_rr_lsu = 1'b0;
        else if (e_lsu_gnt) m_rr_lsu = 1'b1;
        if (wr_valid_i && e_wr_ready) begin
            m_valid[m_head] = 1'b1;
            m_first[m_head] = wr_first_i;
            m_last[m_head]  = wr_last_i;
            m_head  = (m_head + 1) % N;
            m_count = m_count + 1;
        end
        if (en_crash_set_i) m_crash = 1'b1;
        if (m_clear_left > 0) begin
            m_clear_left = m_clear_left - 1;
            if (m_clear_left == 0) begin
                for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
                m_head = 0;
                m_count = 0;
            end
        end else if (clear_i) begin
            m_clear_left = N;
        end
        e_dib = (m_count != 0);
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk_i);
        model_clock();
        #1;
    endtask

    task automatic drive_idle();
        wr_valid_i = 0; wr_first_i = '0; wr_last_i = '0;
        alu_req_i = 0; alu_idx_i = '0; lsu_req_i = 0; lsu_idx_i = '0;
        clear_i = 0; en_crash_set_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive_idle();
        #2;
        checks++;
        if (wr_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready_o);
        end
        checks++;
        if ({busy_o, data_in_buffer_o, en_crash_o, alu_rvalid_o, lsu_rvalid_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/dib/crash/arv/lrv got %b%b%b%b%b want 00000",
                     busy_o, data_in_buffer_o, en_crash_o, alu_rvalid_o, lsu_rvalid_o);
        end
        checks++;
        if (alu_first_o !== '0 || lsu_last_o !== '0 || alu_hit_o !== 1'b0 || wr_idx_o !== '0)
        begin
            errors++; $display("FAIL reset_data: alu_first=%h lsu_last=%h hit=%b idx=%0d want 0",
                               alu_first_o, lsu_last_o, alu_hit_o, wr_idx_o);
        end
        do_reset();
    endtask

    task automatic test_alloc_read();
        do_reset();
        wr_valid_i = 1; wr_first_i = 32'h1000; wr_last_i = 32'h10FF;
        #1;
        checks++;
        if (wr_ready_o !== 1'b1 || wr_idx_o !== 4'd0) begin
            errors++; $display("FAIL alloc_first_idx: ready=%b idx=%0d want 1/0", wr_ready_o, wr_idx_o);
        end
        tick();
        wr_valid_i = 0; alu_req_i = 1; alu_idx_i = 4'd0;
        #1;
        checks++;
        if (alu_gnt_o !== 1'b1) begin
            errors++; $display("FAIL alloc_read_gnt: got %b want 1", alu_gnt_o);
        end
        tick();
        alu_req_i = 0;
        checks++;
        if (alu_rvalid_o !== 1'b1 || alu_first_o !== 32'h1000 || alu_last_o !== 32'h10FF ||
            alu_hit_o !== 1'b1 || data_in_buffer_o !== 1'b1) begin
            errors++;
            $display("FAIL alloc_read_data: rv=%b first=%h last=%h hit=%b dib=%b want 1/1000/10ff/1/1",
                     alu_rvalid_o, alu_first_o, alu_last_o, alu_hit_o, data_in_buffer_o);
        end
        tick();
        checks++;
        if (alu_rvalid_o !== 1'b0 || alu_first_o !== 32'h1000) begin
            errors++; $display("FAIL read_hold: rv=%b first=%h want 0/1000", alu_rvalid_o, alu_first_o);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        alu_req_i = 1; lsu_req_i = 1; alu_idx_i = 4'd0; lsu_idx_i = 4'd1;
        for (int i = 0; i < 4; i++) begin
            bit want_alu;
            want_alu = (i % 2 == 0);
            #1;
            checks++;
            if (alu_gnt_o !== want_alu || lsu_gnt_o !== !want_alu) begin
                errors++; $display("FAIL rr_gnt[%0d]: alu/lsu got %b%b want %b%b",
                                   i, alu_gnt_o, lsu_gnt_o, want_alu, !want_alu);
            end
            tick();
            checks++;
            if (alu_rvalid_o !== want_alu || lsu_rvalid_o !== !want_alu) begin
                errors++; $display("FAIL rr_rvalid[%0d]: alu/lsu got %b%b want %b%b",
                                   i, alu_rvalid_o, lsu_rvalid_o, want_alu, !want_alu);
            end
        end
        alu_req_i = 0; lsu_req_i = 0;
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        wr_valid_i = 1;
        for (int i = 0; i < N; i++) begin
            wr_first_i = 32'h2000 + i; wr_last_i = 32'h20FF + i;
            #1;
            checks++;
            if (wr_ready_o !== 1'b1 || wr_idx_o !== 4'(i)) begin
                errors++; $display("FAIL fill_idx[%0d]: ready=%b idx=%0d want 1/%0d",
                                   i, wr_ready_o, wr_idx_o, i);
            end
            tick();
        end
        #1;
        checks++;
        if (wr_ready_o !== 1'b0 || data_in_buffer_o !== 1'b1) begin
            errors++; $display("FAIL fill_full: ready=%b dib=%b want 0/1", wr_ready_o, data_in_buffer_o);
        end
        wr_valid_i = 0;
        clear_i = 1;
        tick();
        clear_i = 0;
        for (int k = 0; k < 40 && busy_o === 1'b1; k++) tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL fill_clear_timeout: busy=%b want 0", busy_o);
        end
        wr_valid_i = 1;
        #1;
        checks++;
        if (wr_ready_o !== 1'b1 || wr_idx_o !== 4'd0) begin
            errors++; $display("FAIL fill_resume: ready=%b idx=%0d want 1/0", wr_ready_o, wr_idx_o);
        end
        tick();
        wr_valid_i = 0;
    endtask

    task automatic test_clear();
        int busy_cycles;
        int blocked_err;
        busy_cycles = 0;
        blocked_err = 0;
        do_reset();
        wr_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            wr_first_i = 32'h5000 + i; wr_last_i = 32'h5100 + i;
            tick();
        end
        wr_valid_i = 0;
        clear_i = 1; alu_req_i = 1; lsu_req_i = 1; alu_idx_i = 4'd4; lsu_idx_i = 4'd4;
        tick();
        clear_i = 0;
        for (int k = 0; k < 25; k++) begin
            if (k == 2) clear_i = 1;
            #1;
            if (busy_o === 1'b1) begin
                busy_cycles++;
                if (alu_gnt_o !== 1'b0 || lsu_gnt_o !== 1'b0 || wr_ready_o !== 1'b0) blocked_err++;
            end else begin
                alu_req_i = 0; lsu_req_i = 0;
            end
            tick();
            clear_i = 0;
        end
        checks++;
        if (busy_cycles != N) begin
            errors++; $display("FAIL clear_busy_len: got %0d cycles want %0d", busy_cycles, N);
        end
        checks++;
        if (blocked_err != 0) begin
            errors++; $display("FAIL clear_blocked: %0d cycles with gnt/ready high want 0", blocked_err);
        end
        alu_req_i = 1; alu_idx_i = 4'd4;
        tick();
        alu_req_i = 0;
        checks++;
        if (alu_rvalid_o !== 1'b1 || alu_hit_o !== 1'b0 || data_in_buffer_o !== 1'b0) begin
            errors++; $display("FAIL clear_after_read: rv=%b hit=%b dib=%b want 1/0/0",
                               alu_rvalid_o, alu_hit_o, data_in_buffer_o);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        wr_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            wr_first_i = 32'h3000 + i; wr_last_i = 32'h30FF + i;
            tick();
        end
        wr_first_i = 32'h4000; wr_last_i = 32'h40FF;
        lsu_req_i = 1; lsu_idx_i = 4'd3;
        #1;
        checks++;
        if (wr_idx_o !== 4'd3 || lsu_gnt_o !== 1'b1) begin
            errors++; $display("FAIL same_cycle_setup: idx=%0d gnt=%b want 3/1", wr_idx_o, lsu_gnt_o);
        end
        tick();
        wr_valid_i = 0;
        checks++;
        if (lsu_rvalid_o !== 1'b1 || lsu_hit_o !== 1'b0) begin
            errors++; $display("FAIL same_cycle_old: rv=%b hit=%b want 1/0", lsu_rvalid_o, lsu_hit_o);
        end
        tick();
        lsu_req_i = 0;
        checks++;
        if (lsu_rvalid_o !== 1'b1 || lsu_hit_o !== 1'b1 || lsu_first_o !== 32'h4000 ||
            lsu_last_o !== 32'h40FF) begin
            errors++; $display("FAIL same_cycle_new: rv=%b hit=%b first=%h last=%h want 1/1/4000/40ff",
                               lsu_rvalid_o, lsu_hit_o, lsu_first_o, lsu_last_o);
        end
    endtask

    task automatic test_crash();
        do_reset();
        en_crash_set_i = 1;
        #1;
        checks++;
        if (en_crash_o !== 1'b0) begin
            errors++; $display("FAIL crash_early: got %b want 0", en_crash_o);
        end
        tick();
        en_crash_set_i = 0;
        checks++;
        if (en_crash_o !== 1'b1) begin
            errors++; $display("FAIL crash_set: got %b want 1", en_crash_o);
        end
        clear_i = 1;
        tick();
        clear_i = 0;
        repeat (3) tick();
        checks++;
        if (busy_o !== 1'b1 || en_crash_o !== 1'b1) begin
            errors++; $display("FAIL crash_in_clear: busy=%b crash=%b want 1/1", busy_o, en_crash_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || en_crash_o !== 1'b0 || wr_ready_o !== 1'b1) begin
            errors++; $display("FAIL crash_reset: busy=%b crash=%b ready=%b want 0/0/1",
                               busy_o, en_crash_o, wr_ready_o);
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0 || en_crash_o !== 1'b0 || alu_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL crash_after_reset: busy=%b crash=%b rv=%b want 0/0/0",
                               busy_o, en_crash_o, alu_rvalid_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            wr_valid_i = 1'($urandom_range(0, 1));
            wr_first_i = $urandom;
            wr_last_i  = $urandom;
            alu_req_i  = 1'($urandom_range(0, 1));
            alu_idx_i  = 4'($urandom_range(0, N - 1));
            lsu_req_i  = 1'($urandom_range(0, 1));
            lsu_idx_i  = 4'($urandom_range(0, N - 1));
            clear_i    = ($urandom_range(0, 49) == 0);
            en_crash_set_i = ($urandom_range(0, 199) == 0);
            #1;
            model_comb();
            checks++;
            if (alu_gnt_o !== e_alu_gnt || lsu_gnt_o !== e_lsu_gnt) begin
                errors++; $display("FAIL rnd_gnt[%0d]: alu/lsu got %b%b want %b%b",
                                   c, alu_gnt_o, lsu_gnt_o, e_alu_gnt, e_lsu_gnt);
            end
            checks++;
            if (wr_ready_o !== e_wr_ready) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, wr_ready_o, e_wr_ready);
            end
            if (e_wr_ready) begin
                checks++;
                if (wr_idx_o !== 4'(e_wr_idx)) begin
                    errors++; $display("FAIL rnd_idx[%0d]: got %0d want %0d", c, wr_idx_o, e_wr_idx);
                end
            end
            tick();
            checks++;
            if (alu_rvalid_o !== e_alu_rvalid || lsu_rvalid_o !== e_lsu_rvalid) begin
                errors++; $display("FAIL rnd_rvalid[%0d]: alu/lsu got %b%b want %b%b",
                                   c, alu_rvalid_o, lsu_rvalid_o, e_alu_rvalid, e_lsu_rvalid);
            end
            if (e_alu_rvalid) begin
                checks++;
                if (alu_hit_o !== e_alu_hit ||
                    (e_alu_hit && (alu_first_o !== e_alu_first || alu_last_o !== e_alu_last))) begin
                    errors++; $display("FAIL rnd_alu_data[%0d]: hit=%b first=%h last=%h want %b/%h/%h",
                                       c, alu_hit_o, alu_first_o, alu_last_o,
                                       e_alu_hit, e_alu_first, e_alu_last);
                end
            end
            if (e_lsu_rvalid) begin
                checks++;
                if (lsu_hit_o !== e_lsu_hit ||
                    (e_lsu_hit && (lsu_first_o !== e_lsu_first || lsu_last_o !== e_lsu_last))) begin
                    errors++; $display("FAIL rnd_lsu_data[%0d]: hit=%b first=%h last=%h want %b/%h/%h",
                                       c, lsu_hit_o, lsu_first_o, lsu_last_o,
                                       e_lsu_hit, e_lsu_first, e_lsu_last);
                end
            end
            checks++;
            if (busy_o !== (m_clear_left != 0) || data_in_buffer_o !== e_dib ||
                en_crash_o !== m_crash) begin
                errors++; $display("FAIL rnd_status[%0d]: busy/dib/crash got %b%b%b want %b%b%b",
                                   c, busy_o, data_in_buffer_o, en_crash_o,
                                   (m_clear_left != 0), e_dib, m_crash);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alloc_read();
        test_arbitration();
        test_fill();
        test_clear();
        test_same_cycle();
        test_crash();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
